pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of one datapath operand.
REQ-002 SHALL have parameter NUM_DATA, default 4: operand count (PC, rs1 value, rs2 value, immediate).
REQ-003 SHALL have parameter CTRL_W, default 16: control-bit bundle width (RegWrite, MemRead, ALUOp, rd, ...).
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port flush, input, 1: synchronous squash of all held entries.
REQ-007 SHALL have port in_valid, input, 1: upstream entry valid.
REQ-008 SHALL have port in_ready, output, 1: stage accepts an entry this cycle.
REQ-009 SHALL have port in_data, input, NUM_DATA*DATA_W: operand payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W: control payload.
REQ-011 SHALL have port out_valid, output, 1: downstream entry valid.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes the entry.
REQ-013 SHALL have port out_data, output, NUM_DATA*DATA_W: registered operand payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W: registered control payload.
REQ-015 SHALL have port bubble_cnt, output, 16: saturating count of cycles with out_valid=0.

Function
REQ-016 SHALL transfer on in_valid&in_ready (input) and out_valid&out_ready (output), with 1-cycle latency from input transfer to out_valid.
REQ-017 SHALL preserve entry order; SHALL never drop or duplicate an entry except on flush/reset.
REQ-018 SHALL drive out_ctrl=0 and out_data=0 whenever out_valid=0 (guaranteed bubble).
REQ-019 SHALL hold out_data/out_ctrl stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on flush, set all entry valids=0 and zero all stored data/ctrl at the next edge; an input offered in the flush cycle is discarded.
REQ-021 SHALL give flush priority over any simultaneous input or output transfer.
REQ-022 SHALL increment bubble_cnt each cycle out_valid=0, saturating at 16'hFFFF; cleared only by reset.

Reset
REQ-023 SHALL, on reset, clear out_valid, all entry valids, out_data, out_ctrl and bubble_cnt to 0.
REQ-024 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-025 SHALL treat reset mid-transfer as flush; no entry survives.

Configuration
REQ-026 SHALL, with PIPE_SKID_EN defined, implement two entries (main, skid), with in_ready a register equal to !skid_valid.
REQ-027 SHALL, with PIPE_SKID_EN, capture an input into skid when main is valid and stalled; on the next out_ready, main loads from skid and the input may refill skid in the same cycle.
REQ-028 SHALL, with PIPE_SKID_EN, sustain 1 entry/cycle when out_ready=1.
REQ-029 SHALL, without PIPE_SKID_EN, implement one entry with combinational in_ready = !out_valid | out_ready.

Structure
REQ-030 SHALL take default widths and the ctrl field bit offsets from shared package pipe_pkg.
REQ-031 SHALL house the entry storage in one sub-module, pipe_skid_buf, used by this block.

Verification
REQ-032 SHALL test: in_valid=1 data=0x1234, ctrl=0x00A5, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x00A5.
REQ-033 SHALL test: out_ready=0 for 3 cycles with 2 inputs offered (SKID_EN) -> in_ready=0 after 2nd capture; on release, outputs appear in order A then B.
REQ-034 SHALL test: flush=1 while holding 2 entries and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1.
REQ-035 SHALL test: reset during a stall -> out_valid=0, bubble_cnt=0 the following cycle.
REQ-036 SHALL test: idle for 70000 cycles -> bubble_cnt=0xFFFF, with no wrap.
REQ-037 SHALL test: streaming 100 entries with out_ready=1 -> 100 outputs in 101 cycles, in order.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared default widths and control-bundle field offsets for pipeline stage registers
package pipe_pkg;
  localparam int PIPE_DATA_W     = 64;
  localparam int PIPE_NUM_DATA   = 4;
  localparam int PIPE_CTRL_W     = 16;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_OP_LSB = 3;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_RD_LSB     = 7;
  localparam int CTRL_RD_W       = 5;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: entry storage for pipe_stage_reg; empty entries always hold zero payload
// PIPE_SKID_EN selects main+skid entries with registered in_ready, otherwise a single entry
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);
`ifdef PIPE_SKID_EN
  logic         r_main_v, r_skid_v, r_rdy;
  logic [W-1:0] r_main, r_skid;
  logic         w_in_xfer, w_main_free, w_main_v_n, w_skid_v_n;
  logic [W-1:0] w_main_n, w_skid_n;
  // skid only fills while main is stalled; a free main drains skid before taking new input
  always_comb begin
    w_in_xfer   = in_valid & r_rdy;
    w_main_free = !r_main_v | out_ready;
    w_main_v_n  = w_main_free ? (r_skid_v | w_in_xfer) : 1'b1;
    w_main_n    = !w_main_free ? r_main : r_skid_v ? r_skid : w_in_xfer ? in_payload : '0;
    w_skid_v_n  = !w_main_free & (r_skid_v | w_in_xfer);
    w_skid_n    = !w_skid_v_n ? '0 : r_skid_v ? r_skid : in_payload;
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
      r_rdy    <= 1'b1;
    end else begin
      r_main_v <= w_main_v_n;
      r_skid_v <= w_skid_v_n;
      r_main   <= w_main_n;
      r_skid   <= w_skid_n;
      r_rdy    <= !w_skid_v_n;
    end
  end
  assign in_ready    = r_rdy;
  assign out_valid   = r_main_v;
  assign out_payload = r_main;
`else
  logic         r_v;
  logic [W-1:0] r_d;
  logic         w_rdy;
  assign w_rdy = !r_v | out_ready;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (w_rdy) begin
      r_v <= in_valid;
      r_d <= in_valid ? in_payload : '0;
    end
  end
  assign in_ready    = w_rdy;
  assign out_valid   = r_v;
  assign out_payload = r_d;
`endif
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, zeroed bubbles and a saturating bubble counter
// Define PIPE_SKID_EN for a two-entry skid buffer with registered in_ready; default is one entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int NUM_DATA = PIPE_NUM_DATA,
  parameter int CTRL_W   = PIPE_CTRL_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [15:0]                bubble_cnt
);
  localparam int PW = NUM_DATA*DATA_W + CTRL_W;
  logic [PW-1:0] w_out_payload;
  logic [15:0]   r_bubble;
  pipe_skid_buf #(.W(PW)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({in_ctrl, in_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (w_out_payload)
  );
  assign {out_ctrl, out_data} = w_out_payload;
  always_ff @(posedge clk) begin
    if (reset)
      r_bubble <= '0;
    else if (!out_valid && r_bubble != 16'hFFFF)
      r_bubble <= r_bubble + 16'd1;
  end
  assign bubble_cnt = r_bubble;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized scoreboard bench for pipe_stage_reg against a queue reference model
`timescale 1ns/1ps
module tb_pipe_stage_reg;
  localparam int DATA_W   = 64;
  localparam int NUM_DATA = 4;
  localparam int CTRL_W   = 16;
  localparam int DW       = DATA_W*NUM_DATA;
  localparam int PW       = DW + CTRL_W;
  localparam int NW       = (PW+31)/32;
  logic              clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic              in_ready, out_valid;
  logic [DW-1:0]     in_data = '0, out_data;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic [15:0]       bubble_cnt;
  int                n_checks = 0, n_fail = 0, n_out = 0, m_bub = 0, s_out;
  bit                chk_zero = 0, prev_hold = 0;
  logic [PW-1:0]     prev_pl, a, b, c;
  logic [PW-1:0]     q[$];
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );
  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [PW-1:0] rand_item();
    logic [32*NW-1:0] t;
    for (int i = 0; i < NW; i++) t[i*32 +: 32] = $urandom;
    return t[PW-1:0];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [PW-1:0] it);
    in_valid = v;
    {in_ctrl, in_data} = it;
  endtask
  // input side of the model: every accepted entry is expected later, in order
  always @(negedge clk)
    if (!reset && !flush && in_valid && in_ready) q.push_back({in_ctrl, in_data});
  // output monitor: order, hold-while-stalled, zero bubbles, bubble counter model
  always @(negedge clk) begin
    if (prev_hold) begin
      chk("hold_valid", PW'(out_valid), PW'(1));
      chk("hold_payload", {out_ctrl, out_data}, prev_pl);
    end
    if (chk_zero && !out_valid) chk("bubble_zero", {out_ctrl, out_data}, '0);
    if (reset || flush) q.delete();
    else if (out_valid && out_ready) begin
      n_out++;
      chk("queue_nonempty", PW'(q.size() != 0), PW'(1));
      if (q.size() != 0) chk("out_order", {out_ctrl, out_data}, q.pop_front());
    end
    prev_hold = out_valid && !out_ready && !reset && !flush;
    prev_pl   = {out_ctrl, out_data};
    m_bub     = reset ? 0 : (!out_valid && m_bub < 65535) ? m_bub + 1 : m_bub;
  end
  initial begin
    repeat (3) tick();
    reset = 0;
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_payload", {out_ctrl, out_data}, '0);
    chk("rst_bubble", PW'(bubble_cnt), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk_zero = 1;
    // single transfer, one-cycle latency
    out_ready = 1;
    drive(1, {CTRL_W'(16'h00A5), DW'(16'h1234)});
    tick();
    in_valid = 0;
    chk("lat_valid", PW'(out_valid), PW'(1));
    chk("lat_ctrl", PW'(out_ctrl), PW'(16'h00A5));
    chk("lat_data", PW'(out_data), PW'(16'h1234));
    tick();
    chk("lat_empty_valid", PW'(out_valid), PW'(0));
    chk("lat_empty_ctrl", PW'(out_ctrl), '0);
    // three stall cycles with two offers, then release
    a = rand_item();
    b = rand_item();
    out_ready = 0;
    drive(1, a);
    tick();
    drive(1, b);
    tick();
    chk("stall_in_ready", PW'(in_ready), PW'(0));
    tick();
    chk("stall_holds_a", {out_ctrl, out_data}, a);
`ifdef PIPE_SKID_EN
    in_valid = 0;
`endif
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("release_valid", PW'(out_valid), PW'(1));
    chk("release_b", {out_ctrl, out_data}, b);
    tick();
    chk("release_empty", PW'(out_valid), PW'(0));
    // flush while full with an input offered
    out_ready = 0;
    drive(1, rand_item());
    tick();
    drive(1, rand_item());
    tick();
    c = rand_item();
    flush = 1;
    drive(1, c);
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", PW'(out_valid), PW'(0));
    chk("flush_ctrl", PW'(out_ctrl), '0);
    chk("flush_data", PW'(out_data), '0);
    chk("flush_in_ready", PW'(in_ready), PW'(1));
    tick();
    chk("flush_discard", PW'(out_valid), PW'(0));
    // reset during a stall
    drive(1, rand_item());
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_stall_valid", PW'(out_valid), PW'(0));
    chk("rst_stall_bubble", PW'(bubble_cnt), PW'(0));
    chk("rst_stall_in_ready", PW'(in_ready), PW'(1));
    // long idle: counter climbs then saturates
    chk_zero = 0;
    out_ready = 1;
    repeat (65534) tick();
    chk("bub_pre_sat", PW'(bubble_cnt), PW'(65534));
    repeat (70000 - 65534) tick();
    chk("bub_sat", PW'(bubble_cnt), PW'(16'hFFFF));
    chk("bub_model", PW'(bubble_cnt), PW'(m_bub));
    chk_zero = 1;
    // 100-entry stream at full rate
    s_out = n_out;
    for (int i = 0; i < 100; i++) begin
      drive(1, rand_item());
      chk("stream_in_ready", PW'(in_ready), PW'(1));
      tick();
    end
    in_valid = 0;
    tick();
    chk("stream_count", PW'(n_out - s_out), PW'(100));
    // random traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), rand_item());
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (4) tick();
    chk("drain_empty", PW'(q.size()), '0);
    chk("drain_valid", PW'(out_valid), PW'(0));
    chk("final_bubble", PW'(bubble_cnt), PW'(m_bub));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
